// File: rtl/uart_rx_cmd_parser.sv
// uart_rx_cmd_parser
// Frame-level command parser placed after the UART receive stage. A byte
// completes when rx_bps_start falls. Bytes are assembled into 4-byte frames:
// header, command, data, checksum. The checksum is (command + data) mod 256.
// A good frame publishes its command/data with a one-cycle cmd_valid pulse.
// A bad checksum gives a one-cycle cmd_err pulse with err_code = 2'b01.
//
// Optional feature macro: UART_CMD_TIMEOUT_EN
//   When defined, a partial frame that sees no byte for TIMEOUT_CYC cycles
//   is abandoned, and cmd_err pulses with err_code = 2'b10.
//   When undefined, a partial frame waits indefinitely for its bytes.
//
// Parameters
//   HEAD_BYTE    frame start marker
//   TIMEOUT_CYC  inter-byte timeout in clock cycles (2 .. 2^24-1)
// Ports
//   CLK_50M       in   system clock
//   RST_N         in   asynchronous active-low reset
//   rx_bps_start  in   receiver busy flag (high while sampling a UART frame)
//   in_rx_data    in   last received byte, valid once rx_bps_start falls
//   out_cmd       out  command byte of the last good frame
//   out_data      out  data byte of the last good frame
//   cmd_valid     out  one-cycle pulse: new good frame
//   cmd_err       out  one-cycle pulse: frame rejected
//   err_code      out  cause of last rejection (01 checksum, 10 timeout)
//   frame_cnt     out  count of good frames, wraps 255 -> 0
module uart_rx_cmd_parser #(
    parameter logic [7:0]  HEAD_BYTE   = 8'hAA,
    parameter logic [23:0] TIMEOUT_CYC = 24'd500_000
) (
    input  logic       CLK_50M,
    input  logic       RST_N,
    input  logic       rx_bps_start,
    input  logic [7:0] in_rx_data,
    output logic [7:0] out_cmd,
    output logic [7:0] out_data,
    output logic       cmd_valid,
    output logic       cmd_err,
    output logic [1:0] err_code,
    output logic [7:0] frame_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_SUM  = 2'd3
    } state_t;

    // Frame checksum: 8-bit modular sum of the command and data bytes.
    function automatic logic [7:0] f_checksum(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

    state_t     r_state;
    logic       r_start_d;
    logic [7:0] r_cmd;
    logic [7:0] r_data;
    logic [7:0] r_sum;
    logic       w_byte_stb;
    logic       w_to_hit;

    // Delay the busy flag by one cycle to detect its falling edge.
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            r_start_d <= 1'b0;
        end else begin
            r_start_d <= rx_bps_start;
        end
    end

    // r_start_d resets low, so a flag that is already low after reset yields no strobe.
    assign w_byte_stb = r_start_d & ~rx_bps_start;

`ifdef UART_CMD_TIMEOUT_EN
    logic [23:0] r_to_cnt;

    // A strobe in the terminal-count cycle wins over the timeout.
    assign w_to_hit = (r_state != ST_IDLE) && !w_byte_stb &&
                      (r_to_cnt == (TIMEOUT_CYC - 24'd1));

    // Inter-byte idle counter: runs only while a frame is partially assembled.
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            r_to_cnt <= 24'd0;
        end else if (w_byte_stb || (r_state == ST_IDLE) || w_to_hit) begin
            r_to_cnt <= 24'd0;
        end else begin
            r_to_cnt <= r_to_cnt + 24'd1;
        end
    end
`else
    // Without the timeout build, TIMEOUT_CYC is deliberately not consumed.
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYC;
    assign w_to_hit         = 1'b0;
`endif

    // Frame FSM. It also drives every registered output.
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= ST_IDLE;
            r_cmd     <= 8'd0;
            r_data    <= 8'd0;
            r_sum     <= 8'd0;
            out_cmd   <= 8'd0;
            out_data  <= 8'd0;
            cmd_valid <= 1'b0;
            cmd_err   <= 1'b0;
            err_code  <= 2'b00;
            frame_cnt <= 8'd0;
        end else begin
            cmd_valid <= 1'b0;
            cmd_err   <= 1'b0;
            if (w_to_hit) begin
                r_state  <= ST_IDLE;
                cmd_err  <= 1'b1;
                err_code <= 2'b10;
            end else if (w_byte_stb) begin
                case (r_state)
                    ST_IDLE: begin
                        // Bytes outside a frame are dropped silently.
                        if (in_rx_data == HEAD_BYTE) begin
                            r_state <= ST_CMD;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_CMD: begin
                        // A header value here is an ordinary command byte; there is no resync.
                        r_cmd   <= in_rx_data;
                        r_state <= ST_DATA;
                    end
                    ST_DATA: begin
                        r_data  <= in_rx_data;
                        r_sum   <= f_checksum(r_cmd, in_rx_data);
                        r_state <= ST_SUM;
                    end
                    ST_SUM: begin
                        if (in_rx_data == r_sum) begin
                            out_cmd   <= r_cmd;
                            out_data  <= r_data;
                            cmd_valid <= 1'b1;
                            frame_cnt <= frame_cnt + 8'd1;
                        end else begin
                            cmd_err  <= 1'b1;
                            err_code <= 2'b01;
                        end
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end else begin
                r_state <= r_state;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cmd_parser.sv
// Directed self-checking bench for uart_rx_cmd_parser (TIMEOUT_CYC = 1000).
// Inputs change on the falling clock edge. Outputs are sampled on falling edges.
module tb_uart_rx_cmd_parser;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_bps_start;
    logic [7:0] in_rx_data;
    logic [7:0] out_cmd;
    logic [7:0] out_data;
    logic       cmd_valid;
    logic       cmd_err;
    logic [1:0] err_code;
    logic [7:0] frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int n_err    = 0;
    int n_both   = 0;

    // Pulse samples at the first and second falling edge after a byte strobe.
    logic s_cv1, s_ce1, s_cv2, s_ce2;

    uart_rx_cmd_parser #(
        .HEAD_BYTE  (8'hAA),
        .TIMEOUT_CYC(24'd1000)
    ) dut (
        .CLK_50M     (clk),
        .RST_N       (rst_n),
        .rx_bps_start(rx_bps_start),
        .in_rx_data  (in_rx_data),
        .out_cmd     (out_cmd),
        .out_data    (out_data),
        .cmd_valid   (cmd_valid),
        .cmd_err     (cmd_err),
        .err_code    (err_code),
        .frame_cnt   (frame_cnt)
    );

    always #10 clk = ~clk;

    // Count output pulses seen on each falling edge.
    always @(negedge clk) begin
        if (cmd_valid) n_valid++;
        if (cmd_err) n_err++;
        if (cmd_valid && cmd_err) n_both++;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_bps_start = 1'b1;
        repeat (19) @(negedge clk);
        rx_bps_start = 1'b0;
        in_rx_data   = b;
        @(negedge clk);
        s_cv1 = cmd_valid;
        s_ce1 = cmd_err;
        @(negedge clk);
        s_cv2 = cmd_valid;
        s_ce2 = cmd_err;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] d, input logic [7:0] s);
        send_byte(8'hAA);
        send_byte(c);
        send_byte(d);
        send_byte(s);
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        rx_bps_start = 1'b0;
        in_rx_data   = 8'h00;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({out_cmd, out_data, cmd_valid, cmd_err, err_code, frame_cnt} !== 28'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h/%h/%b/%b/%b/%h required all zero",
                     out_cmd, out_data, cmd_valid, cmd_err, err_code, frame_cnt);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        // The flag is low coming out of reset, so no strobe may occur.
        n_checks++;
        if ((n_valid !== 0) || (n_err !== 0) || (frame_cnt !== 8'd0)) begin
            n_fail++;
            $display("FAIL reset_release: valid=%0d err=%0d cnt=%0d required 0/0/0",
                     n_valid, n_err, frame_cnt);
        end
    endtask

    task automatic test_good_frame();
        int nv0, ne0;
        nv0 = n_valid;
        ne0 = n_err;
        send_frame(8'h12, 8'h34, 8'h46);
        n_checks++;
        if ({s_cv1, s_cv2} !== 2'b10) begin
            n_fail++;
            $display("FAIL good_valid_timing: got %b required 10", {s_cv1, s_cv2});
        end
        n_checks++;
        if ({out_cmd, out_data, frame_cnt} !== {8'h12, 8'h34, 8'd1}) begin
            n_fail++;
            $display("FAIL good_outputs: got %h %h %0d required 12 34 1", out_cmd, out_data, frame_cnt);
        end
        n_checks++;
        if ((n_valid - nv0 !== 1) || (n_err !== ne0)) begin
            n_fail++;
            $display("FAIL good_pulses: valid=%0d err=%0d required 1 0", n_valid - nv0, n_err - ne0);
        end
    endtask

    task automatic test_bad_checksum();
        int nv0;
        nv0 = n_valid;
        send_frame(8'h12, 8'h34, 8'h00);
        n_checks++;
        if ({s_ce1, s_ce2, s_cv1, err_code} !== 5'b10001) begin
            n_fail++;
            $display("FAIL bad_err: got ce=%b%b cv=%b code=%b required ce=10 cv=0 code=01",
                     s_ce1, s_ce2, s_cv1, err_code);
        end
        n_checks++;
        if ({out_cmd, out_data, frame_cnt} !== {8'h12, 8'h34, 8'd1} || n_valid !== nv0) begin
            n_fail++;
            $display("FAIL bad_hold: got %h %h %0d required 12 34 1", out_cmd, out_data, frame_cnt);
        end
        send_frame(8'h01, 8'h02, 8'h03);
        n_checks++;
        if ({s_cv1, out_cmd, out_data, frame_cnt, err_code} !== {1'b1, 8'h01, 8'h02, 8'd2, 2'b01}) begin
            n_fail++;
            $display("FAIL bad_recover: got cv=%b %h %h %0d code=%b required 1 01 02 2 01",
                     s_cv1, out_cmd, out_data, frame_cnt, err_code);
        end
    endtask

    task automatic test_junk();
        int nv0, ne0;
        nv0 = n_valid;
        ne0 = n_err;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h55);
        n_checks++;
        if ((n_valid !== nv0) || (n_err !== ne0)) begin
            n_fail++;
            $display("FAIL junk_silent: valid=%0d err=%0d required 0 0", n_valid - nv0, n_err - ne0);
        end
        send_frame(8'h01, 8'hFF, 8'h00);
        n_checks++;
        if ({s_cv1, out_cmd, out_data, frame_cnt} !== {1'b1, 8'h01, 8'hFF, 8'd3}) begin
            n_fail++;
            $display("FAIL junk_wrap_sum: got cv=%b %h %h %0d required 1 01 ff 3",
                     s_cv1, out_cmd, out_data, frame_cnt);
        end
    endtask

    task automatic test_timeout();
        int ne0, first;
        ne0   = n_err;
        first = 0;
        send_byte(8'hAA);
        send_byte(8'h12);
        // Falling edges 1..6 after the last strobe were consumed by send_byte.
        for (int i = 7; i <= 1200; i++) begin
            @(negedge clk);
            if (cmd_err && (first == 0)) first = i;
        end
`ifdef UART_CMD_TIMEOUT_EN
        n_checks++;
        if ((first !== 1001) || (err_code !== 2'b10) || (n_err - ne0 !== 1)) begin
            n_fail++;
            $display("FAIL timeout_err: edge=%0d code=%b count=%0d required 1001 10 1",
                     first, err_code, n_err - ne0);
        end
        send_frame(8'h07, 8'h08, 8'h0F);
        n_checks++;
        if ({s_cv1, out_cmd, out_data, frame_cnt} !== {1'b1, 8'h07, 8'h08, 8'd4}) begin
            n_fail++;
            $display("FAIL timeout_recover: got cv=%b %h %h %0d required 1 07 08 4",
                     s_cv1, out_cmd, out_data, frame_cnt);
        end
`else
        n_checks++;
        if ((n_err !== ne0) || (err_code !== 2'b01)) begin
            n_fail++;
            $display("FAIL no_timeout: err=%0d code=%b required 0 01", n_err - ne0, err_code);
        end
        send_byte(8'h34);
        send_byte(8'h46);
        n_checks++;
        if ({s_cv1, out_cmd, out_data, frame_cnt} !== {1'b1, 8'h12, 8'h34, 8'd4}) begin
            n_fail++;
            $display("FAIL no_timeout_complete: got cv=%b %h %h %0d required 1 12 34 4",
                     s_cv1, out_cmd, out_data, frame_cnt);
        end
`endif
    endtask

    task automatic test_async_reset();
        int nv0, ne0;
        send_byte(8'hAA);
        send_byte(8'h12);
        #5;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_cmd, out_data, cmd_valid, cmd_err, err_code, frame_cnt} !== 28'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %h/%h/%b/%b/%b/%h required all zero",
                     out_cmd, out_data, cmd_valid, cmd_err, err_code, frame_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        nv0 = n_valid;
        ne0 = n_err;
        send_byte(8'h34);
        send_byte(8'h46);
        n_checks++;
        if ((n_valid !== nv0) || (n_err !== ne0)) begin
            n_fail++;
            $display("FAIL reset_discard: valid=%0d err=%0d required 0 0", n_valid - nv0, n_err - ne0);
        end
        send_frame(8'h07, 8'h08, 8'h0F);
        n_checks++;
        if ({s_cv1, out_cmd, out_data, frame_cnt} !== {1'b1, 8'h07, 8'h08, 8'd1}) begin
            n_fail++;
            $display("FAIL reset_then_frame: got cv=%b %h %h %0d required 1 07 08 1",
                     s_cv1, out_cmd, out_data, frame_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int nv0, ne0;
        logic [7:0] c, d;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        nv0 = n_valid;
        ne0 = n_err;
        for (int i = 0; i < 256; i++) begin
            c = i[7:0];
            d = c ^ 8'h5A;
            send_frame(c, d, c + d);
            if (i == 254) begin
                n_checks++;
                if (frame_cnt !== 8'd255) begin
                    n_fail++;
                    $display("FAIL cnt_255: got %0d required 255", frame_cnt);
                end
            end
        end
        n_checks++;
        if ((n_valid - nv0 !== 256) || (n_err !== ne0) || (frame_cnt !== 8'd0)) begin
            n_fail++;
            $display("FAIL cnt_wrap: valid=%0d err=%0d cnt=%0d required 256 0 0",
                     n_valid - nv0, n_err - ne0, frame_cnt);
        end
        n_checks++;
        if ({out_cmd, out_data} !== {8'hFF, 8'hA5}) begin
            n_fail++;
            $display("FAIL last_frame: got %h %h required ff a5", out_cmd, out_data);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_junk();
        test_timeout();
        test_async_reset();
        test_back_to_back();
        n_checks++;
        if (n_both !== 0) begin
            n_fail++;
            $display("FAIL valid_err_exclusive: overlaps=%0d required 0", n_both);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_cmd_parser.md
# uart_rx_cmd_parser

Frame-level command parser sitting directly downstream of the UART receive stage. Detects each completed byte from the receiver's `rx_bps_start` handshake, assembles 4-byte frames (header, command, data, checksum), and emits a validated command/data pair with a one-cycle strobe. Checksum failures and optional inter-byte timeouts are flagged for the control logic on the Zircon board (LED/segment/command decoders).

## Interface
- `HEAD_BYTE`, 8'hAA: frame start marker.
- `TIMEOUT_CYC`, 24'd500_000: inter-byte timeout in clock cycles (10 ms at 50 MHz); legal range 2..2^24-1.

- `CLK_50M`  in  1  system clock, 50 MHz.
- `RST_N`  in  1  reset, asynchronous, active-low.
- `rx_bps_start`  in  1  receiver busy flag; high while a UART frame is being sampled.
- `in_rx_data`  in  8  last received byte; stable from the falling edge of `rx_bps_start` until the next frame completes.
- `out_cmd`  out  8  command byte of last good frame.
- `out_data`  out  8  data byte of last good frame.
- `cmd_valid`  out  1  one-cycle pulse: new good frame on `out_cmd`/`out_data`.
- `cmd_err`  out  1  one-cycle pulse: frame rejected.
- `err_code`  out  2  cause of last rejection: 01 checksum, 10 timeout, 00 none yet; held until the next rejection.
- `frame_cnt`  out  8  count of good frames, wraps 255→0.

## Operation
- Byte strobe: register `rx_bps_start` into `start_d`. `byte_stb = start_d & ~rx_bps_start`. Cycle T is the first cycle `rx_bps_start` is seen low; `in_rx_data` is sampled in T.
- FSM states are IDLE, CMD, DATA, SUM. All transitions occur only on `byte_stb`, except timeout.
  - IDLE: byte == HEAD_BYTE → CMD. Any other byte is discarded silently with no error.
  - CMD: latch byte into `cmd_r` → DATA. A HEAD_BYTE value here is treated as an ordinary command byte; there is no resync.
  - DATA: latch byte into `data_r`, and set `sum_r = cmd_r + byte` (8-bit, mod 256) → SUM.
  - SUM: if byte == `sum_r`:
    - `out_cmd` ← `cmd_r` and `out_data` ← `data_r`.
    - Pulse `cmd_valid`.
    - `frame_cnt` ← `frame_cnt` + 1.
  - SUM: otherwise pulse `cmd_err`, set `err_code` = 01, and leave `out_cmd`/`out_data` unchanged.
  - SUM: next state is IDLE in both cases.
- `cmd_valid` and `cmd_err` are never high in the same cycle.
- Reset, which may arrive mid-frame, forces:
  - State IDLE, and `start_d` = 0.
  - `out_cmd`, `out_data`, `cmd_valid`, `cmd_err`, `err_code`, `frame_cnt`, and the timeout counter all 0.
  - Any partial frame is discarded.

## Timing
- `byte_stb` is combinational in cycle T. State, latches, and outputs update at the T→T+1 edge.
- `cmd_valid`/`cmd_err` are registered and high during cycle T+1 only, where T is the SUM byte's strobe. `out_cmd`/`out_data` are valid in that same cycle and held afterwards.
- Back-to-back frames are limited by the UART line rate (≥ ~10 bit times per byte), so every strobe is accepted. The FSM never stalls.
- A `rx_bps_start` held high indefinitely generates no strobe.
- A `rx_bps_start` already low coming out of reset generates no strobe, because `start_d` resets to 0.

## Configuration
- `UART_CMD_TIMEOUT_EN` defined:
  - A 24-bit counter clears on every `byte_stb` and while in IDLE, and increments in CMD/DATA/SUM.
  - When it reaches TIMEOUT_CYC−1 with no strobe that cycle, the FSM returns to IDLE. In the next cycle `cmd_err` pulses and `err_code` = 10.
  - A strobe in the same cycle as the terminal count wins: the byte is processed normally and the counter clears.
- `UART_CMD_TIMEOUT_EN` undefined: there is no counter and no timeout path. A partial frame waits indefinitely for its remaining bytes, and `err_code` never takes the value 10.

## Test plan
Byte-driving convention for all scenarios: hold `rx_bps_start` high for 20 cycles, drop it low while presenting `in_rx_data`, and keep it low for ≥5 cycles between bytes. Use `TIMEOUT_CYC` = 1000.

- Good frame AA 12 34 46 → one `cmd_valid` pulse the cycle after the 4th strobe; `out_cmd` = 12, `out_data` = 34, `frame_cnt` = 1, `cmd_err` never high.
- Bad checksum AA 12 34 00 → one `cmd_err` pulse, `err_code` = 01, `out_cmd`/`out_data`/`frame_cnt` unchanged; a following AA 01 02 03 is accepted with `cmd_valid`.
- Leading junk 00 FF 55 then AA 01 FF 00 → no error pulse from the junk; good frame with `out_cmd` = 01, `out_data` = FF; checksum wraps correctly to 00.
- Timeout (macro defined): AA 12 then idle 1200 cycles → `cmd_err` with `err_code` = 10 after 1000 cycles; a subsequent AA 07 08 0F → `cmd_valid`. With the macro undefined, the same stimulus gives no error, and a following 34 46 completes the frame.
- Reset asserted asynchronously after AA 12 → all outputs 0 immediately. After release, 34 46 produces no `cmd_valid`, and a full frame then succeeds.
- 256 good frames → `frame_cnt` wraps to 0, with exactly 256 `cmd_valid` pulses.
